// File: rtl/dbg_pkg.sv
// Shared types and constants for the register-file debug responder.
package dbg_pkg;

  // Register index width for a 32-entry architectural register file.
  localparam int REG_IDX_W = 5;

  // Width of the register data carried in a response beat.
  localparam int DATA_W = 32;

  // Command sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_STALL   = 3'd1,
    ST_READ    = 3'd2,
    ST_RESP    = 3'd3,
    ST_RELEASE = 3'd4
  } dbg_state_e;

  // One response beat as presented on the resp_* outputs.
  typedef struct packed {
    logic [REG_IDX_W-1:0] reg_idx;
    logic [DATA_W-1:0]    data;
    logic                 last;
    logic                 mismatch;
    logic                 timeout;
  } dbg_resp_t;

endpackage

// File: rtl/dbg_timeout_counter.sv
// Counts cycles spent waiting for the pipeline to acknowledge a stall.
// terminal rises once LIMIT-1 enabled cycles have elapsed after a clear
// and holds until the next clear.
module dbg_timeout_counter #(
  parameter int LIMIT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] count;

  assign terminal = (count == CW'(LIMIT - 1));

  // Cycle counter: cleared while idle, advances each waiting cycle, parks at terminal.
  always_ff @(posedge clock) begin
    // NOTE: flops use non-blocking assignment so every register samples pre-edge values.
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !terminal) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_debug_port.sv
// On-chip debug responder: freezes the pipeline on command, reads one or all
// architectural registers through a dedicated regfile read port, optionally
// compares against an expected value, and streams results back one beat at a
// time over a valid/ready response channel.
module regfile_debug_port
  import dbg_pkg::*;
#(
  parameter int NUM_REGS    = 32,
  parameter int DATA_WIDTH  = DATA_W,  // must equal dbg_pkg::DATA_W (response struct width)
  parameter int ERR_WIDTH   = 16,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  // Command channel from the debug initiator
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_all,
  input  logic [REG_IDX_W-1:0]  cmd_reg,
  input  logic                  cmd_check,
  input  logic [DATA_WIDTH-1:0] cmd_expected,
  // Pipeline stall handshake
  output logic                  stall_req,
  input  logic                  stall_ack,
  // Debug regfile read port (combinational read)
  output logic [REG_IDX_W-1:0]  rf_ctrl_read,
  input  logic [DATA_WIDTH-1:0] rf_data,
  // Response channel to the debug initiator
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [REG_IDX_W-1:0]  resp_reg,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_last,
  output logic                  resp_mismatch,
  output logic                  resp_timeout,
  output logic [ERR_WIDTH-1:0]  error_count
);

  dbg_state_e state, state_next;

  // Latched command
  logic                  all_q;
  logic                  check_q;
  logic [DATA_WIDTH-1:0] expected_q;
  logic [REG_IDX_W-1:0]  idx;

  // Current response beat and mismatch tally
  dbg_resp_t             resp_q;
  logic [ERR_WIDTH-1:0]  err_q;

  // Handshake and timer controls
  logic accept;
  logic resp_fire;
  logic tmo_clear;
  logic tmo_enable;
  logic tmo_terminal;
  logic ack_timed_out;

  assign accept        = cmd_valid && cmd_ready;
  assign resp_fire     = resp_valid && resp_ready;
  assign ack_timed_out = (state == ST_STALL) && !stall_ack && tmo_terminal;

  dbg_timeout_counter #(
    .LIMIT (ACK_TIMEOUT)
  ) u_ack_timer (
    .clock    (clock),
    .reset    (reset),
    .clear    (tmo_clear),
    .enable   (tmo_enable),
    .terminal (tmo_terminal)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and state-decoded handshake outputs.
  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    state_next = state;
    cmd_ready  = 1'b0;
    stall_req  = 1'b0;
    resp_valid = 1'b0;
    tmo_clear  = 1'b0;
    tmo_enable = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        tmo_clear = 1'b1;
        if (cmd_valid) state_next = ST_STALL;
      end
      ST_STALL: begin
        stall_req  = 1'b1;
        tmo_enable = 1'b1;
        // A late acknowledge on the terminal cycle still wins over the abort.
        if (stall_ack)         state_next = ST_READ;
        else if (tmo_terminal) state_next = ST_RESP;
      end
      ST_READ: begin
        stall_req  = 1'b1;
        state_next = ST_RESP;
      end
      ST_RESP: begin
        stall_req  = 1'b1;
        resp_valid = 1'b1;
        if (resp_ready) state_next = resp_q.last ? ST_RELEASE : ST_READ;
      end
      ST_RELEASE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Command latch and register index walk across a dump.
  always_ff @(posedge clock) begin
    if (reset) begin
      all_q      <= 1'b0;
      check_q    <= 1'b0;
      expected_q <= '0;
      idx        <= '0;
    end else if (accept) begin
      all_q      <= cmd_all;
      check_q    <= cmd_check && !cmd_all;
      expected_q <= cmd_expected;
      idx        <= cmd_all ? '0 : cmd_reg;
    end else if ((state == ST_RESP) && resp_ready && !resp_q.last) begin
      idx <= idx + 1'b1;
    end
  end

  // Response beat: captured from the regfile in READ, or a zero-data abort beat.
  always_ff @(posedge clock) begin
    if (reset) begin
      resp_q <= '0;
    end else if (state == ST_READ) begin
      resp_q.reg_idx  <= idx;
      resp_q.data     <= rf_data;
      resp_q.last     <= !all_q || (idx == REG_IDX_W'(NUM_REGS - 1));
      resp_q.mismatch <= check_q && (rf_data != expected_q);
      resp_q.timeout  <= 1'b0;
    end else if (ack_timed_out) begin
      resp_q.reg_idx  <= idx;
      resp_q.data     <= '0;
      resp_q.last     <= 1'b1;
      resp_q.mismatch <= 1'b0;
      resp_q.timeout  <= 1'b1;
    end
  end

  // Saturating count of mismatched beats, bumped when the beat is consumed.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_q <= '0;
    end else if (resp_fire && resp_q.mismatch && (err_q != {ERR_WIDTH{1'b1}})) begin
      err_q <= err_q + 1'b1;
    end
  end

  assign rf_ctrl_read  = idx;
  assign resp_reg      = resp_q.reg_idx;
  assign resp_data     = resp_q.data;
  assign resp_last     = resp_q.last;
  assign resp_mismatch = resp_q.mismatch;
  assign resp_timeout  = resp_q.timeout;
  assign error_count   = err_q;

endmodule

// File: tb/tb_regfile_debug_port.sv
// Self-checking bench for regfile_debug_port: directed scenarios with literal
// expectations, then randomized commands against a transaction-level model.
module tb_regfile_debug_port;

  localparam int NUM_REGS    = 32;
  localparam int DW          = 32;
  localparam int EW          = 16;
  localparam int ACK_TIMEOUT = 64;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid, cmd_ready, cmd_all, cmd_check;
  logic [4:0]    cmd_reg;
  logic [DW-1:0] cmd_expected;
  logic          stall_req, stall_ack;
  logic [4:0]    rf_ctrl_read;
  logic [DW-1:0] rf_data;
  logic          resp_valid, resp_ready, resp_last, resp_mismatch, resp_timeout;
  logic [4:0]    resp_reg;
  logic [DW-1:0] resp_data;
  logic [EW-1:0] error_count;

  // Processor-side register file, read combinationally by the debug port.
  logic [DW-1:0] rf [NUM_REGS];
  assign rf_data = rf[rf_ctrl_read];

  regfile_debug_port #(
    .NUM_REGS    (NUM_REGS),
    .DATA_WIDTH  (DW),
    .ERR_WIDTH   (EW),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_all       (cmd_all),
    .cmd_reg       (cmd_reg),
    .cmd_check     (cmd_check),
    .cmd_expected  (cmd_expected),
    .stall_req     (stall_req),
    .stall_ack     (stall_ack),
    .rf_ctrl_read  (rf_ctrl_read),
    .rf_data       (rf_data),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_reg      (resp_reg),
    .resp_data     (resp_data),
    .resp_last     (resp_last),
    .resp_mismatch (resp_mismatch),
    .resp_timeout  (resp_timeout),
    .error_count   (error_count)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic expire(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // ---------------- processor and initiator behaviour ----------------
  int cur_delay  = 0;  // stall cycles before the pipeline acknowledges
  int ready_mode = 0;  // 0: resp_ready high, 1: random, 2: held low
  int stall_cnt  = 0;

  initial begin
    stall_ack  = 1'b0;
    resp_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      if (stall_req === 1'b1) begin
        stall_cnt++;
        stall_ack = (stall_cnt > cur_delay);
      end else begin
        stall_cnt = 0;
        stall_ack = 1'b0;
      end
      case (ready_mode)
        0:       resp_ready = 1'b1;
        1:       resp_ready = 1'($urandom_range(0, 1));
        default: resp_ready = 1'b0;
      endcase
    end
  end

  // ---------------- transaction-level reference model ----------------
  typedef struct {
    int unsigned   reg_idx;
    logic [DW-1:0] data;
    bit            last;
    bit            mm;
    bit            tmo;
  } beat_t;

  beat_t       exp_q[$];
  bit          m_busy = 0;  // a command is in flight (accept .. release)
  bit          m_rel  = 0;  // this cycle is the one-cycle stall release
  bit          m_gap  = 0;  // previous cycle consumed a non-final beat
  int unsigned m_err  = 0;

  // Compare process: every cycle, DUT outputs against the model.
  always @(negedge clock) begin
    beat_t b;
    if (reset) begin
      exp_q.delete();
      m_busy = 0;
      m_rel  = 0;
      m_gap  = 0;
      m_err  = 0;
    end else begin
      check("cmd_ready", cmd_ready, !m_busy);
      check("stall_req", stall_req, m_busy && !m_rel);
      check("error_count", error_count, m_err);
      if (m_gap) check("beat_spacing_valid", resp_valid, 0);
      m_gap = 0;
      if (m_rel) begin
        m_busy = 0;
        m_rel  = 0;
      end
      if (resp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("resp_valid_unexpected", resp_valid, 0);
        end else begin
          b = exp_q[0];
          if (!b.tmo) check("resp_reg", resp_reg, b.reg_idx);
          check("resp_data", resp_data, b.data);
          check("resp_last", resp_last, b.last);
          check("resp_mismatch", resp_mismatch, b.mm);
          check("resp_timeout", resp_timeout, b.tmo);
          if (resp_ready) begin
            void'(exp_q.pop_front());
            if (b.mm && m_err < (2**EW - 1)) m_err++;
            if (b.last) m_rel = 1;
            else        m_gap = 1;
          end
        end
      end
      if (cmd_valid && cmd_ready) begin
        m_busy = 1;
        if (cur_delay >= ACK_TIMEOUT) begin
          b.reg_idx = cmd_all ? 0 : cmd_reg;
          b.data = '0; b.last = 1; b.mm = 0; b.tmo = 1;
          exp_q.push_back(b);
        end else if (cmd_all) begin
          for (int i = 0; i < NUM_REGS; i++) begin
            b.reg_idx = i; b.data = rf[i]; b.last = (i == NUM_REGS - 1);
            b.mm = 0; b.tmo = 0;
            exp_q.push_back(b);
          end
        end else begin
          b.reg_idx = cmd_reg; b.data = rf[cmd_reg]; b.last = 1;
          b.mm = cmd_check && (rf[cmd_reg] != cmd_expected); b.tmo = 0;
          exp_q.push_back(b);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input bit all, input logic [4:0] r, input bit chk,
                       input logic [DW-1:0] e, input int delay);
    int k;
    cur_delay = delay;
    @(posedge clock);
    #1;
    cmd_valid = 1'b1; cmd_all = all; cmd_reg = r; cmd_check = chk; cmd_expected = e;
    k = 0;
    do begin @(negedge clock); k++; end while (!cmd_ready && k < 200);
    if (!cmd_ready) expire("cmd_accept");
    @(posedge clock);
    #1;
    // Scramble the command bus so only latched values can matter.
    cmd_valid = 1'b0; cmd_all = 1'($urandom); cmd_reg = 5'($urandom);
    cmd_check = 1'($urandom); cmd_expected = $urandom;
  endtask

  task automatic wait_valid(input string name, output int k);
    k = 0;
    do begin @(negedge clock); k++; end while (!resp_valid && k < 1000);
    if (!resp_valid) expire(name);
  endtask

  task automatic wait_fire(input string name, output int k);
    k = 0;
    do begin @(negedge clock); k++; end while (!(resp_valid && resp_ready) && k < 2000);
    if (!(resp_valid && resp_ready)) expire(name);
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    do begin @(negedge clock); k++; end while (!cmd_ready && k < 3000);
    if (!cmd_ready) expire(name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios, then random traffic ----------------
  initial begin
    int k;
    logic [4:0]    r;
    logic [DW-1:0] e;
    int            d;
    bit            all, chk;

    cmd_valid = 0; cmd_all = 0; cmd_reg = 0; cmd_check = 0; cmd_expected = 0;
    for (int i = 0; i < NUM_REGS; i++) rf[i] = i;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clock);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_stall_req", stall_req, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_reg", resp_reg, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_resp_flags", {resp_last, resp_mismatch, resp_timeout}, 0);
    check("rst_rf_ctrl_read", rf_ctrl_read, 0);
    check("rst_error_count", error_count, 0);

    // Single read of r5, ack three cycles into the stall
    issue(0, 5'd5, 0, 0, 3);
    wait_valid("single_wait", k);
    check("single_reg", resp_reg, 5);
    check("single_data", resp_data, 5);
    check("single_last", resp_last, 1);
    check("single_mismatch", resp_mismatch, 0);
    @(negedge clock);
    check("single_release_stall", stall_req, 0);
    @(negedge clock);
    check("single_idle_ready", cmd_ready, 1);
    check("single_error_count", error_count, 0);

    // Checked read that fails, then one that passes
    rf[2] = 0;
    issue(0, 5'd2, 1, 32'd4, 1);
    wait_valid("chk_bad_wait", k);
    check("chk_bad_mismatch", resp_mismatch, 1);
    check("chk_bad_data", resp_data, 0);
    wait_idle("chk_bad_idle");
    check("chk_bad_error_count", error_count, 1);
    issue(0, 5'd4, 1, 32'd4, 0);
    wait_valid("chk_ok_wait", k);
    check("chk_ok_mismatch", resp_mismatch, 0);
    wait_idle("chk_ok_idle");
    check("chk_ok_error_count", error_count, 1);
    rf[2] = 2;

    // Full dump, initiator always ready: one beat every two cycles
    issue(1, 5'd13, 1, 0, 2);
    for (int i = 0; i < NUM_REGS; i++) begin
      wait_fire("dump_beat", k);
      check("dump_reg", resp_reg, i);
      check("dump_data", resp_data, i);
      check("dump_last", resp_last, i == NUM_REGS - 1);
      if (i > 0) check("dump_gap", k, 2);
    end
    wait_idle("dump_idle");
    check("dump_error_count", error_count, 1);

    // Dump with beat 7 held off for ten cycles
    issue(1, 5'd0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      wait_fire("bp_beat", k);
      check("bp_reg", resp_reg, i);
    end
    ready_mode = 2;
    wait_valid("bp_hold_wait", k);
    check("bp_hold_reg", resp_reg, 7);
    repeat (10) begin
      @(negedge clock);
      check("bp_hold_valid", resp_valid, 1);
      check("bp_hold_reg", resp_reg, 7);
      check("bp_hold_data", resp_data, 7);
      check("bp_hold_last", resp_last, 0);
    end
    ready_mode = 0;
    for (int i = 7; i < NUM_REGS; i++) begin
      wait_fire("bp_beat", k);
      check("bp_reg", resp_reg, i);
      check("bp_data", resp_data, i);
    end
    wait_idle("bp_idle");

    // Stall never acknowledged: abort after ACK_TIMEOUT stall cycles
    issue(0, 5'd3, 0, 0, 255);
    wait_valid("tmo_wait", k);
    check("tmo_latency", k, ACK_TIMEOUT + 1);
    check("tmo_flag", resp_timeout, 1);
    check("tmo_data", resp_data, 0);
    check("tmo_last", resp_last, 1);
    @(negedge clock);
    check("tmo_release_stall", stall_req, 0);
    @(negedge clock);
    check("tmo_idle_ready", cmd_ready, 1);

    // Ack on the very last allowed stall cycle still completes the read
    issue(0, 5'd9, 0, 0, ACK_TIMEOUT - 1);
    wait_valid("late_ack_wait", k);
    check("late_ack_timeout", resp_timeout, 0);
    check("late_ack_data", resp_data, 9);
    check("late_ack_latency", k, ACK_TIMEOUT + 2);
    wait_idle("late_ack_idle");

    // Ack one cycle too late aborts
    issue(0, 5'd9, 0, 0, ACK_TIMEOUT);
    wait_valid("edge_tmo_wait", k);
    check("edge_tmo_flag", resp_timeout, 1);
    check("edge_tmo_latency", k, ACK_TIMEOUT + 1);
    wait_idle("edge_tmo_idle");

    // Reset in the middle of a dump, after beat 10 is consumed
    issue(1, 5'd0, 0, 0, 1);
    for (int i = 0; i <= 10; i++) begin
      wait_fire("rst_dump_beat", k);
      check("rst_dump_reg", resp_reg, i);
    end
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("midrst_resp_valid", resp_valid, 0);
    check("midrst_stall_req", stall_req, 0);
    check("midrst_cmd_ready", cmd_ready, 1);
    check("midrst_error_count", error_count, 0);
    issue(0, 5'd7, 1, 32'd7, 2);
    wait_valid("midrst_read_wait", k);
    check("midrst_read_reg", resp_reg, 7);
    check("midrst_read_data", resp_data, 7);
    check("midrst_read_mismatch", resp_mismatch, 0);
    wait_idle("midrst_read_idle");

    // Randomized traffic against the model
    ready_mode = 1;
    repeat (40) begin
      for (int i = 0; i < NUM_REGS; i++)
        rf[i] = ($urandom_range(0, 3) == 0) ? DW'(i) : $urandom;
      all = ($urandom_range(0, 4) == 0);
      r   = 5'($urandom);
      chk = 1'($urandom);
      e   = $urandom_range(0, 1) ? rf[r] : $urandom;
      case ($urandom_range(0, 9))
        0:       d = ACK_TIMEOUT;
        1:       d = ACK_TIMEOUT - 1;
        default: d = $urandom_range(0, 6);
      endcase
      issue(all, r, chk, e, d);
      wait_idle("rand_idle");
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end
    ready_mode = 0;
    repeat (3) @(negedge clock);
    check("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
